// File: rtl/cut_vector_sequencer.sv
// cut_vector_sequencer: stores stimulus/expected-response pairs, drives them
// into a circuit-under-test, compares each sampled response, and compacts the
// responses into a MISR signature. Supports single-pass and looped runs.
module cut_vector_sequencer #(
    parameter  int          IN_W      = 41,
    parameter  int          OUT_W     = 32,
    parameter  int          DEPTH     = 16,
    parameter  int          SETTLE    = 1,
    parameter  logic [31:0] MISR_POLY = 32'h04C11DB7,
    localparam int          AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_stim,
    input  logic [OUT_W-1:0] ld_exp,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW:0]      num_vec,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    vec_idx,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      err_cnt,
    output logic             first_fail_vld,
    output logic [AW-1:0]    first_fail_idx,
    output logic [OUT_W-1:0] sig
);

    localparam int            SW      = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_W = SW'(SETTLE);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [OUT_W-1:0] POLY  = OUT_W'(MISR_POLY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [SW-1:0]      settle_cnt;
    logic [AW-1:0]      last_idx;
    logic               loop_mode;
    logic               mismatch;
    logic [OUT_W-1:0]   misr_next;

    logic [IN_W-1:0]    stim_mem [DEPTH];
    logic [OUT_W-1:0]   exp_mem  [DEPTH];

    // Vector memory write port; loads are locked out while a run is in progress.
    // NOTE: storage arrays get no reset, so they map onto plain RAM and keep
    // their contents across rst; only the control state is reset.
    always_ff @(posedge clk) begin
        if (ld_we && !busy) begin
            stim_mem[ld_addr] <= ld_stim;
            exp_mem[ld_addr]  <= ld_exp;
        end
    end

    // Response compare and next MISR value for the vector currently applied.
    always_comb begin
        mismatch  = (cut_out != exp_mem[vec_idx]);
        misr_next = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ cut_out;
    end

    // Run control FSM with all status outputs registered.
    // NOTE: every register here uses <= so that memory reads on the start edge
    // see the pre-write contents (read-before-write on an address collision).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            last_idx       <= '0;
            loop_mode      <= 1'b0;
            cut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            vec_idx        <= '0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            sig            <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        sig            <= '0;
                        vec_idx        <= '0;
                        cut_in         <= stim_mem[0];
                        settle_cnt     <= SETTLE_W;
                        loop_mode      <= loop_en;
                        if (num_vec > DEPTH_W) begin
                            last_idx <= AW'(DEPTH - 1);
                        end else begin
                            last_idx <= AW'(num_vec - 1'b1);
                        end
                        if (num_vec == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (settle_cnt != SW'(1)) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        // Sampling edge: compare, compact, advance.
                        sig <= misr_next;
                        if (mismatch) begin
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_idx <= vec_idx;
                            end
                        end
                        settle_cnt <= SETTLE_W;
                        if (vec_idx == last_idx) begin
                            if (pass_cnt != 16'hFFFF) begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                            if (loop_mode && !stop) begin
                                vec_idx <= '0;
                                cut_in  <= stim_mem[0];
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            vec_idx <= vec_idx + 1'b1;
                            cut_in  <= stim_mem[vec_idx + 1'b1];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cut_vector_sequencer.sv
// Directed testbench for cut_vector_sequencer with a small combinational CUT
// model and a reference MISR; expected values are computed from the vector
// tables held in the bench.
module tb_cut_vector_sequencer;

    localparam int IN_W   = 41;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld_we = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [IN_W-1:0]  ld_stim = '0;
    logic [OUT_W-1:0] ld_exp = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [AW:0]      num_vec = '0;
    logic [IN_W-1:0]  cut_in;
    logic [OUT_W-1:0] cut_out;
    logic             busy;
    logic             done;
    logic [AW-1:0]    vec_idx;
    logic [15:0]      pass_cnt;
    logic [15:0]      err_cnt;
    logic             first_fail_vld;
    logic [AW-1:0]    first_fail_idx;
    logic [OUT_W-1:0] sig;

    logic             fault_en = 1'b0;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [IN_W-1:0]  seq[$];
    logic             busy_seen = 1'b0;

    always #5 clk = ~clk;

    cut_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE), .MISR_POLY(POLY)
    ) dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_stim(ld_stim),
        .ld_exp(ld_exp), .start(start), .stop(stop), .loop_en(loop_en), .num_vec(num_vec),
        .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done), .vec_idx(vec_idx),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .first_fail_vld(first_fail_vld),
        .first_fail_idx(first_fail_idx), .sig(sig)
    );

    function automatic logic [IN_W-1:0] stim_of(input int i);
        logic [31:0] lo;
        lo = 32'(32'h9E3779B9 * (i + 1));
        return {9'(i * 5 + 1), lo};
    endfunction

    function automatic logic [OUT_W-1:0] cut_f(input logic [IN_W-1:0] x);
        return x[31:0] ^ {23'h0, x[40:32]};
    endfunction

    function automatic logic [OUT_W-1:0] misr(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] d);
        return ({s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? POLY : 32'h0)) ^ d;
    endfunction

    // CUT model, with an optional single-bit fault on vector 2.
    always_comb begin
        cut_out = cut_f(cut_in);
        if (fault_en && cut_in == stim_of(2)) cut_out = cut_out ^ 32'h1;
    end

    // Record each distinct vector applied while a run is active.
    always @(negedge clk) begin
        if (busy) begin
            busy_seen <= 1'b1;
            if (seq.size() == 0 || seq[seq.size() - 1] != cut_in) seq.push_back(cut_in);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = AW'(a); ld_stim = s; ld_exp = e;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic start_run(input int nv, input logic lp);
        @(negedge clk);
        seq.delete();
        num_vec = (AW + 1)'(nv); loop_en = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    logic [OUT_W-1:0] sig1, sig2, s;
    int cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_cut_in", 64'(cut_in), 64'h0);
        check("rst_busy_done", {62'h0, busy, done}, 64'h0);
        check("rst_counts", {pass_cnt, err_cnt, 32'h0}, 64'h0);
        check("rst_sig", 64'(sig), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) load(i, stim_of(i), cut_f(stim_of(i)));

        sig1 = '0;
        for (int i = 0; i < 4; i++) sig1 = misr(sig1, cut_f(stim_of(i)));
        sig2 = '0;
        for (int i = 0; i < 4; i++) sig2 = misr(sig2, cut_f(stim_of(i)) ^ ((i == 2) ? 32'h1 : 32'h0));

        // Scenario 1: four matching vectors
        start_run(4, 1'b0);
        check("s1_busy", 64'(busy), 64'h1);
        check("s1_cut_in0", 64'(cut_in), 64'(stim_of(0)));
        wait_done(40, cyc);
        check("s1_cycles", 64'(cyc), 64'd8);
        check("s1_err", 64'(err_cnt), 64'h0);
        check("s1_pass", 64'(pass_cnt), 64'h1);
        check("s1_ffv", 64'(first_fail_vld), 64'h0);
        check("s1_sig", 64'(sig), 64'(sig1));
        check("s1_hold_cut_in", 64'(cut_in), 64'(stim_of(3)));
        check("s1_vec_idx", 64'(vec_idx), 64'd3);

        // Scenario 2: CUT response for vector 2 disagrees with its expected word
        fault_en = 1'b1;
        start_run(4, 1'b0);
        wait_done(40, cyc);
        fault_en = 1'b0;
        check("s2_err", 64'(err_cnt), 64'h1);
        check("s2_ffv", 64'(first_fail_vld), 64'h1);
        check("s2_ffi", 64'(first_fail_idx), 64'd2);
        check("s2_sig", 64'(sig), 64'(sig2));

        // Scenario 3: looped run, stop raised during the third pass
        start_run(3, 1'b1);
        cyc = 0;
        while (pass_cnt != 16'd2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("s3_pass2_cycles", 64'(cyc), 64'd12);
        stop = 1'b1;
        wait_done(60, cyc);
        stop = 1'b0;
        check("s3_pass", 64'(pass_cnt), 64'd3);
        check("s3_done", 64'(done), 64'h1);
        check("s3_seq_len", 64'(seq.size()), 64'd9);
        for (int i = 0; i < 9 && i < seq.size(); i++)
            check($sformatf("s3_seq%0d", i), 64'(seq[i]), 64'(stim_of(i % 3)));

        // Scenario 4: zero-length run
        @(negedge clk);
        busy_seen = 1'b0;
        start_run(0, 1'b0);
        check("s4_done", 64'(done), 64'h1);
        check("s4_busy_seen", 64'(busy_seen), 64'h0);
        check("s4_counts", {pass_cnt, err_cnt, 31'h0, first_fail_vld}, 64'h0);
        check("s4_sig", 64'(sig), 64'h0);

        // Scenario 5: asynchronous reset mid-run, then a clean rerun
        start_run(4, 1'b0);
        repeat (4) @(negedge clk);
        check("s5_sig_nonzero_before", 64'(sig != 0), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("s5_rst_cut_in", 64'(cut_in), 64'h0);
        check("s5_rst_flags", {61'h0, busy, done, first_fail_vld}, 64'h0);
        check("s5_rst_idx_pass", {44'h0, vec_idx, pass_cnt}, 64'h0);
        check("s5_rst_sig", 64'(sig), 64'h0);
        #1 rst = 1'b0;
        start_run(4, 1'b0);
        wait_done(40, cyc);
        check("s5_cycles", 64'(cyc), 64'd8);
        check("s5_sig", 64'(sig), 64'(sig1));
        check("s5_err", 64'(err_cnt), 64'h0);

        // Scenario 6: loads during a run are ignored
        start_run(4, 1'b0);
        cyc = 0;
        while (!done && cyc < 40) begin
            ld_we = 1'b1; ld_addr = vec_idx; ld_stim = '1; ld_exp = 32'hDEAD_BEEF;
            @(negedge clk);
            cyc++;
        end
        ld_we = 1'b0;
        check("s6_cycles", 64'(cyc), 64'd8);
        check("s6_err", 64'(err_cnt), 64'h0);
        check("s6_sig", 64'(sig), 64'(sig1));
        start_run(4, 1'b0);
        wait_done(40, cyc);
        check("s6_rerun_sig", 64'(sig), 64'(sig1));

        // num_vec above DEPTH clamps to a full 16-vector pass
        start_run(20, 1'b0);
        wait_done(100, cyc);
        check("clamp_cycles", 64'(cyc), 64'(2 * DEPTH));
        check("clamp_vec_idx", 64'(vec_idx), 64'(DEPTH - 1));
        s = '0;
        for (int i = 0; i < DEPTH; i++) s = misr(s, cut_f(stim_of(i)));
        check("clamp_sig", 64'(sig), 64'(s));

        // start with a same-cycle write to address 0: old stimulus is applied
        @(negedge clk);
        seq.delete();
        num_vec = 5'd4; loop_en = 1'b0; start = 1'b1;
        ld_we = 1'b1; ld_addr = '0; ld_stim = stim_of(7) ^ 41'h1; ld_exp = cut_f(stim_of(7) ^ 41'h1);
        @(negedge clk);
        start = 1'b0; ld_we = 1'b0;
        check("rbw_cut_in", 64'(cut_in), 64'(stim_of(0)));
        wait_done(40, cyc);
        check("rbw_err", 64'(err_cnt), 64'h1);
        check("rbw_ffi", {62'h0, first_fail_vld, 1'b0} | 64'(first_fail_idx), 64'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
